// File: rtl/usb_data_buffer.sv
// 64-byte circular FIFO between usb_rx / AHB-lite writers and AHB-lite / usb_tx readers.
// Sticky overflow/underflow flags record dropped strobes until flush or reset.
module usb_data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     store_rx_packet_data,
    input  logic [7:0]               rx_packet_data,
    input  logic                     store_tx_data,
    input  logic [7:0]               tx_data,
    input  logic                     get_rx_data,
    output logic [7:0]               rx_data,
    input  logic                     get_tx_packet_data,
    output logic [7:0]               tx_packet_data,
    output logic [$clog2(DEPTH):0]   buffer_occupancy,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    logic       wr_req;
    logic       rd_req;
    logic       wr_ok;
    logic       rd_ok;
    logic [7:0] wr_byte;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_req  = store_rx_packet_data | store_tx_data;
        rd_req  = get_tx_packet_data | get_rx_data;
        wr_byte = store_rx_packet_data ? rx_packet_data : tx_data;
        rd_ok   = rd_req && (count != '0);
        // A full buffer still takes a write when a read frees the slot in the same cycle.
        wr_ok   = wr_req && ((count < FULL) || rd_ok);
    end

    // NOTE: sequential state uses non-blocking assignments so a same-edge read sees the old mem[rptr].
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is cleared on reset as well, since reset must leave every register at 0.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            rx_data        <= '0;
            tx_packet_data <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wptr] <= wr_byte;
                wptr      <= wptr + 1'b1;
            end
            if (rd_ok) begin
                if (get_tx_packet_data) begin
                    tx_packet_data <= mem[rptr];
                end else begin
                    rx_data <= mem[rptr];
                end
                rptr <= rptr + 1'b1;
            end
            if (wr_req && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd_req && !rd_ok) begin
                underflow <= 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    assign buffer_occupancy = count;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_usb_data_buffer;

    localparam int DEPTH = 64;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       store_rx_packet_data = 1'b0;
    logic [7:0] rx_packet_data = '0;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data = '0;
    logic       get_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic       get_tx_packet_data = 1'b0;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_rx = '0;
    logic [7:0] m_tx = '0;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    always #5 tb_clk = ~tb_clk;

    usb_data_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (tb_clk),
        .rst                  (rst),
        .flush                (flush),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .overflow             (overflow),
        .underflow            (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies the strobes sampled at this edge to the FIFO model.
    task automatic model_update();
        bit wr, rd, rd_ok, wr_ok;
        if (rst) begin
            q.delete();
            m_rx = '0; m_tx = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            wr    = store_rx_packet_data || store_tx_data;
            rd    = get_rx_data || get_tx_packet_data;
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) begin
                if (get_tx_packet_data) m_tx = q.pop_front();
                else                    m_rx = q.pop_front();
            end
            if (wr_ok) q.push_back(store_rx_packet_data ? rx_packet_data : tx_data);
            if (wr && !wr_ok) m_ovf = 1'b1;
            if (rd && !rd_ok) m_unf = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        model_update();
        #1;
        check("occupancy", 32'(buffer_occupancy), 32'(q.size()));
        check("rx_data", 32'(rx_data), 32'(m_rx));
        check("tx_packet_data", 32'(tx_packet_data), 32'(m_tx));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic drive(input bit r, input bit f, input bit srx, input logic [7:0] rxd,
                         input bit stx, input logic [7:0] txd, input bit grx, input bit gtx);
        rst = r; flush = f;
        store_rx_packet_data = srx; rx_packet_data = rxd;
        store_tx_data = stx; tx_data = txd;
        get_rx_data = grx; get_tx_packet_data = gtx;
        step();
        rst = 0; flush = 0; store_rx_packet_data = 0; store_tx_data = 0;
        get_rx_data = 0; get_tx_packet_data = 0;
    endtask

    initial begin
        int wp, rp;

        // Reset
        drive(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        drive(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        check("reset_occ", 32'(buffer_occupancy), 0);
        check("reset_rx", 32'(rx_data), 0);
        check("reset_tx", 32'(tx_packet_data), 0);
        check("reset_flags", 32'({overflow, underflow}), 0);

        // RX fill and drain
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'(i), 0, 8'h00, 0, 0);
        check("fill4_occ", 32'(buffer_occupancy), 4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
            check("drain4_rx", 32'(rx_data), 32'(i));
        end
        check("drain4_occ", 32'(buffer_occupancy), 0);

        // Full and wrap
        for (int i = 0; i < 64; i++) drive(0, 0, 1, 8'(8'h40 + i), 0, 8'h00, 0, 0);
        check("full_occ", 32'(buffer_occupancy), 64);
        drive(0, 0, 1, 8'h80, 0, 8'h00, 0, 0);
        check("full_ovf", 32'(overflow), 1);
        check("full_ovf_occ", 32'(buffer_occupancy), 64);
        drive(0, 0, 0, 8'h00, 1, 8'hAA, 0, 1);
        check("full_rw_tx", 32'(tx_packet_data), 32'h40);
        check("full_rw_occ", 32'(buffer_occupancy), 64);
        for (int i = 0; i < 64; i++) drive(0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        check("wrap_last", 32'(rx_data), 32'hAA);
        check("wrap_occ", 32'(buffer_occupancy), 0);

        // Empty read with concurrent write
        drive(0, 0, 1, 8'h55, 0, 8'h00, 1, 0);
        check("empty_unf", 32'(underflow), 1);
        check("empty_occ", 32'(buffer_occupancy), 1);
        check("empty_rx_hold", 32'(rx_data), 32'hAA);
        drive(0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        check("empty_next", 32'(rx_data), 32'h55);

        // Write priority and flush
        drive(0, 0, 1, 8'h11, 1, 8'h22, 0, 0);
        check("prio_occ", 32'(buffer_occupancy), 1);
        drive(0, 0, 0, 8'h00, 0, 8'h00, 1, 1);
        check("prio_tx", 32'(tx_packet_data), 32'h11);
        check("prio_rx_hold", 32'(rx_data), 32'h55);
        drive(0, 0, 1, 8'h33, 0, 8'h00, 0, 0);
        drive(0, 1, 1, 8'h44, 0, 8'h00, 0, 0);
        check("flush_occ", 32'(buffer_occupancy), 0);
        check("flush_flags", 32'({overflow, underflow}), 0);

        // Reset mid-operation
        for (int i = 0; i < 10; i++) drive(0, 0, 1, 8'(8'hC0 + i), 0, 8'h00, 0, 0);
        check("pre_rst_occ", 32'(buffer_occupancy), 10);
        drive(1, 0, 1, 8'hEE, 0, 8'h00, 0, 0);
        check("midrst_occ", 32'(buffer_occupancy), 0);
        check("midrst_out", 32'({rx_data, tx_packet_data, overflow, underflow}), 0);

        // Random traffic in phases biased toward filling, draining, and balance
        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 3)
                0:       begin wp = 85; rp = 20; end
                1:       begin wp = 20; rp = 85; end
                default: begin wp = 50; rp = 50; end
            endcase
            rst                  = ($urandom_range(999, 0) < 2);
            flush                = ($urandom_range(999, 0) < 5);
            store_rx_packet_data = ($urandom_range(99, 0) < wp);
            store_tx_data        = ($urandom_range(99, 0) < wp / 2);
            rx_packet_data       = 8'($urandom);
            tx_data              = 8'($urandom);
            get_rx_data          = ($urandom_range(99, 0) < rp);
            get_tx_packet_data   = ($urandom_range(99, 0) < rp / 2);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
